// File: rtl/trace_uart_tx.sv
// trace_uart_tx: streams captured {pc, alu} samples as "PPPPPPPP AAAAAAAA\r\n" over an 8N1 UART.
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_in,
  output logic              tx,
  output logic              busy,
  output logic [DROP_W-1:0] dropped
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] BMAX = 16'(CLKS_PER_BIT - 1);
  state_t            state_q;
  logic [63:0]       active_q, pend_q;
  logic              pend_v_q, tx_q;
  logic [4:0]        char_q;
  logic [2:0]        bit_q;
  logic [15:0]       baud_q;
  logic [DROP_W-1:0] drop_q;
  logic [3:0]        nib_idx, nib;
  logic [7:0]        hx, chr;
  logic              bit_end, line_end, tx_d;
  // Chars 0-7 are pc nibbles 15..8, chars 9-16 are alu nibbles 7..0.
  always_comb begin
    nib_idx  = char_q < 5'd8 ? 4'(5'd15 - char_q) : 4'(5'd16 - char_q);
    nib      = active_q[{nib_idx, 2'b00} +: 4];
    hx       = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    chr      = char_q == 5'd8 ? 8'h20 : char_q == 5'd17 ? 8'h0D : char_q == 5'd18 ? 8'h0A : hx;
    bit_end  = baud_q == BMAX;
    line_end = state_q == STOP && bit_end && char_q == 5'd18;
    tx_d     = state_q == DATA ? chr[bit_q] : state_q != START;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      pend_v_q <= 1'b0;
      drop_q   <= '0;
      char_q   <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
    end else begin
      tx_q   <= tx_d;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 16'd1;
      case (state_q)
        IDLE: if (sample_valid) begin
          active_q <= {pc_in, alu_in};
          char_q   <= '0;
          state_q  <= START;
        end
        START: if (bit_end) begin
          bit_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        default: if (bit_end) begin
          state_q <= START;
          char_q  <= char_q + 5'd1;
          if (char_q == 5'd18) begin
            char_q <= '0;
            if (pend_v_q) active_q <= pend_q;
            else if (sample_valid) active_q <= {pc_in, alu_in};
            else state_q <= IDLE;
          end
        end
      endcase
      // At a line boundary the pending slot is consumed, so a same-cycle sample refills it.
      if (line_end && pend_v_q) begin
        pend_v_q <= sample_valid;
        if (sample_valid) pend_q <= {pc_in, alu_in};
      end else if (sample_valid && state_q != IDLE && !line_end) begin
        if (!pend_v_q) begin
          pend_q   <= {pc_in, alu_in};
          pend_v_q <= 1'b1;
        end else if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      end
    end
  end
  assign tx      = tx_q;
  assign busy    = state_q != IDLE || pend_v_q;
  assign dropped = drop_q;
endmodule

// File: tb/tb_trace_uart_tx.sv
// tb_trace_uart_tx: directed checks of line format, timing, buffering, drop saturation and reset.
module tb_trace_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] alu_in = '0;
  logic        tx, busy;
  logic [1:0]  dropped;
  int passed = 0;
  int total = 0;

  trace_uart_tx #(.CLKS_PER_BIT(4), .DROP_W(2)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .pc_in(pc_in), .alu_in(alu_in),
    .tx(tx), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic strobe(input logic [31:0] pc, input logic [31:0] alu);
    @(negedge clk);
    sample_valid = 1'b1;
    pc_in = pc;
    alu_in = alu;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Samples every cycle of all 190 bit periods starting on the next negedge.
  task automatic rx_line(input logic [31:0] pc, input logic [31:0] alu);
    string hexs = "0123456789ABCDEF";
    logic [9:0] fr;
    logic [7:0] ex;
    logic [3:0] n;
    logic s;
    int bad = 0;
    check("idle_before_line", {63'd0, tx}, 64'd1);
    for (int c = 0; c < 19; c++) begin
      if (c < 8) n = pc[31-4*c -: 4];
      else if (c > 8 && c < 17) n = alu[31-4*(c-9) -: 4];
      else n = 4'd0;
      ex = c == 8 ? 8'h20 : c == 17 ? 8'h0D : c == 18 ? 8'h0A : 8'(hexs[n]);
      for (int b = 0; b < 10; b++) begin
        @(negedge clk);
        s = tx;
        repeat (3) begin
          @(negedge clk);
          if (tx !== s) bad++;
        end
        fr[b] = s;
      end
      check($sformatf("char%0d_frame", c), {54'd0, fr}, {54'd0, 1'b1, ex, 1'b0});
    end
    check("bit_width", 64'(bad), 64'd0);
  endtask

  initial begin
    sample_valid = 1'b1;
    pc_in = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", {63'd0, tx}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_dropped", {62'd0, dropped}, 64'd0);
    end
    rst = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx", {63'd0, tx}, 64'd1);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    strobe(32'h0000_0004, 32'h0000_002A);
    check("busy_during", {63'd0, busy}, 64'd1);
    rx_line(32'h0000_0004, 32'h0000_002A);
    check("busy_after", {63'd0, busy}, 64'd0);

    strobe(32'h89AB_CDEF, 32'h0123_4567);
    rx_line(32'h89AB_CDEF, 32'h0123_4567);
    check("busy_after_hex", {63'd0, busy}, 64'd0);

    strobe(32'h1111_2222, 32'h3333_4444);
    fork
      rx_line(32'h1111_2222, 32'h3333_4444);
      begin
        repeat (10) @(negedge clk);
        strobe(32'hAAAA_5555, 32'hFEDC_BA98);
      end
    join
    rx_line(32'hAAAA_5555, 32'hFEDC_BA98);
    check("b2b_dropped", {62'd0, dropped}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd0);

    strobe(32'h0000_000A, 32'h0000_000B);
    fork
      rx_line(32'h0000_000A, 32'h0000_000B);
      begin
        repeat (10) @(negedge clk);
        strobe(32'h0000_00B0, 32'h0000_00B1);
        repeat (10) @(negedge clk);
        strobe(32'h0000_00C0, 32'h0000_00C1);
      end
    join
    check("ovf_dropped", {62'd0, dropped}, 64'd1);
    rx_line(32'h0000_00B0, 32'h0000_00B1);
    check("ovf_busy", {63'd0, busy}, 64'd0);
    repeat (50) @(negedge clk);
    check("ovf_no_c_line", {63'd0, tx}, 64'd1);

    strobe(32'hDEAD_B0EF, 32'h0000_0001);
    strobe(32'h0000_0E0E, 32'h0000_0E0E);
    for (int i = 0; i < 5; i++) strobe(32'(i), 32'(i));
    check("sat_dropped", {62'd0, dropped}, 64'd3);
    check("sat_busy", {63'd0, busy}, 64'd1);

    repeat (195) @(negedge clk);
    check("mid_line_tx", {63'd0, tx}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", {63'd0, tx}, 64'd1);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_dropped", {62'd0, dropped}, 64'd0);
    repeat (20) @(negedge clk);
    check("midrst_quiet_tx", {63'd0, tx}, 64'd1);
    check("midrst_quiet_busy", {63'd0, busy}, 64'd0);

    strobe(32'hCAFE_F00D, 32'h7654_3210);
    rx_line(32'hCAFE_F00D, 32'h7654_3210);
    check("fresh_busy", {63'd0, busy}, 64'd0);
    check("fresh_dropped", {62'd0, dropped}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
